norn_filt: RTL and testbench

NORN_FILT -- requirements
Module: norn_filt

---
 rtl/norn_pkg.sv | 22 ++
 rtl/norn_qual.sv | 28 ++
 rtl/norn_filt.sv | 132 +++++++++++++
 tb/tb_norn_filt.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/norn_pkg.sv
// Shared types and sizing helpers for the norn_filt enable-loop fault filter.
package norn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam int BLANK_W   = 8;
  localparam int N_MIN     = 2;
  localparam int N_MAX     = 16;
  localparam int FILT_MIN  = 1;
  localparam int FILT_MAX  = 15;
  localparam int BLANK_MAX = 255;

  function automatic int cnt_w(input int filt);
    return $clog2(filt + 1);
  endfunction

endpackage

// File: rtl/norn_qual.sv
// Per-channel debounce: a saturating run-length counter that flags the FILT-th
// consecutive active sample while counting is enabled.
module norn_qual import norn_pkg::*; #(
  parameter int FILT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic active,
  output logic qual
);

  localparam int CW = cnt_w(FILT);

  logic [CW-1:0] cnt;

  // Any gap in activity, or leaving RUN, restarts the run length from zero.
  always_ff @(posedge clk) begin
    if (rst || !run || !active) begin
      cnt <= '0;
    end else if (cnt != CW'(FILT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign qual = active && (cnt == CW'(FILT - 1));

endmodule

// File: rtl/norn_filt.sv
// Enable-loop fault filter: blanks after enable, debounces N channels and
// latches a sticky fault with the offending channel vector until cleared.
module norn_filt #(
  parameter int N     = 4,
  parameter int FILT  = 3,
  parameter int BLANK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         CELV,
  input  logic         CELG,
  input  logic         SUB,
  input  logic         en,
  input  logic         clr,
  input  logic [N-1:0] i,
  input  logic [N-1:0] mask,
  output logic         o,
  output logic         flt,
  output logic [N-1:0] flt_src,
  output logic [1:0]   st
);

  // The BLANK parameter shadows the imported state literal, so that state is
  // always named through the package scope in this module.
  import norn_pkg::*;

  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("norn_filt: N must be within 2..16");
  end
  if (FILT < FILT_MIN || FILT > FILT_MAX) begin : g_bad_filt
    $error("norn_filt: FILT must be within 1..15");
  end
  if (BLANK < 0 || BLANK > BLANK_MAX) begin : g_bad_blank
    $error("norn_filt: BLANK must be within 0..255");
  end

  state_t             state, state_nxt;
  logic [BLANK_W-1:0] bcnt, bcnt_nxt;
  logic [N-1:0]       active, qual, hit;
  logic               run_cnt, fault_entry, clr_take;
  logic               unused_pins;

  assign unused_pins = ^{CELV, CELG, SUB};

  assign active      = i & ~mask;
  assign hit         = (state == RUN) ? qual : '0;
  assign fault_entry = |hit;
  assign clr_take    = (state == FAULT) && clr;
  assign run_cnt     = (state == RUN) && (state_nxt == RUN);

  for (genvar k = 0; k < N; k++) begin : g_ch
    norn_qual #(.FILT(FILT)) u_qual (
      .clk    (clk),
      .rst    (rst),
      .run    (run_cnt),
      .active (active[k]),
      .qual   (qual[k])
    );
  end

  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    case (state)
      IDLE: begin
        if (en) begin
          if (BLANK == 0) begin
            state_nxt = RUN;
          end else begin
            state_nxt = norn_pkg::BLANK;
            bcnt_nxt  = BLANK_W'(BLANK);
          end
        end
      end
      norn_pkg::BLANK: begin
        if (!en) begin
          state_nxt = IDLE;
          bcnt_nxt  = '0;
        end else begin
          bcnt_nxt = bcnt - BLANK_W'(1);
          if (bcnt == BLANK_W'(1)) begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (fault_entry) begin
          state_nxt = FAULT;
        end else if (!en) begin
          state_nxt = IDLE;
        end
      end
      FAULT: begin
        // Clear wins over anything else; enable decides whether to re-blank.
        if (clr) begin
          if (!en) begin
            state_nxt = IDLE;
          end else if (BLANK == 0) begin
            state_nxt = RUN;
          end else begin
            state_nxt = norn_pkg::BLANK;
            bcnt_nxt  = BLANK_W'(BLANK);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bcnt    <= '0;
      o       <= 1'b1;
      flt     <= 1'b0;
      flt_src <= '0;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
      o     <= (state_nxt != FAULT);
      flt   <= (state_nxt == FAULT);
      if (fault_entry) begin
        flt_src <= hit;
      end else if (clr_take) begin
        flt_src <= '0;
      end
    end
  end

  assign st = state;

endmodule

// File: tb/tb_norn_filt.sv
// Randomized and directed bench for norn_filt against a run-length reference model.
module tb_norn_filt;

  localparam int N     = 4;
  localparam int FILT  = 3;
  localparam int BLANK = 8;

  logic         clk = 1'b0;
  logic         rst, en, clr, celv, celg, sub;
  logic [N-1:0] i, mask;
  logic         o, flt;
  logic [N-1:0] flt_src;
  logic [1:0]   st;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 blanking, 2 running, 3 faulted.
  int           m_mode = 0;
  int           m_blank_left = 0;
  int           m_streak[N];
  bit           m_flt = 1'b0;
  logic [N-1:0] m_src = '0;

  always #5 clk = ~clk;

  norn_filt #(.N(N), .FILT(FILT), .BLANK(BLANK)) dut (
    .clk     (clk),
    .rst     (rst),
    .CELV    (celv),
    .CELG    (celg),
    .SUB     (sub),
    .en      (en),
    .clr     (clr),
    .i       (i),
    .mask    (mask),
    .o       (o),
    .flt     (flt),
    .flt_src (flt_src),
    .st      (st)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int           s[N];
    logic [N-1:0] hits;
    if (rst) begin
      m_mode = 0;
      m_blank_left = 0;
      m_flt = 1'b0;
      m_src = '0;
      for (int k = 0; k < N; k++) m_streak[k] = 0;
      return;
    end
    case (m_mode)
      0: if (en) begin
        m_mode = (BLANK == 0) ? 2 : 1;
        m_blank_left = BLANK;
      end
      1: if (!en) m_mode = 0;
         else begin
           m_blank_left--;
           if (m_blank_left == 0) m_mode = 2;
         end
      2: begin
        hits = '0;
        for (int k = 0; k < N; k++) begin
          s[k] = (i[k] && !mask[k]) ? m_streak[k] + 1 : 0;
          if (s[k] >= FILT) hits[k] = 1'b1;
        end
        if (hits != '0) begin
          m_mode = 3;
          m_flt = 1'b1;
          m_src = hits;
          for (int k = 0; k < N; k++) m_streak[k] = 0;
        end else if (!en) begin
          m_mode = 0;
          for (int k = 0; k < N; k++) m_streak[k] = 0;
        end else begin
          for (int k = 0; k < N; k++) m_streak[k] = s[k];
        end
      end
      default: if (clr) begin
        m_flt = 1'b0;
        m_src = '0;
        m_mode = en ? ((BLANK == 0) ? 2 : 1) : 0;
        m_blank_left = BLANK;
      end
    endcase
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic c,
                               input logic [N-1:0] iv, input logic [N-1:0] mv,
                               input string tag);
    rst  = r;
    en   = e;
    clr  = c;
    i    = iv;
    mask = mv;
    @(posedge clk);
    model_step();
    #1;
    checkOutput({tag, ".st"},  32'(st),      32'(m_mode));
    checkOutput({tag, ".o"},   32'(o),       32'(m_mode != 3));
    checkOutput({tag, ".flt"}, 32'(flt),     32'(m_flt));
    checkOutput({tag, ".src"}, 32'(flt_src), 32'(m_src));
  endtask

  task automatic repeat_stim(input int n, input logic r, input logic e, input logic c,
                             input logic [N-1:0] iv, input logic [N-1:0] mv,
                             input string tag);
    for (int k = 0; k < n; k++) applyStimulus(r, e, c, iv, mv, tag);
  endtask

  initial begin
    logic [N-1:0] rnd_i, rnd_m;
    celv = 1'b1;
    celg = 1'b0;
    sub  = 1'b0;
    for (int k = 0; k < N; k++) m_streak[k] = 0;

    repeat_stim(2, 1, 0, 0, '0, '0, "reset");
    checkOutput("reset_st", 32'(st), 32'd0);
    checkOutput("reset_o", 32'(o), 32'd1);

    // Enable rise: eight blanking edges with a channel active that must be ignored.
    repeat_stim(8, 0, 1, 0, 4'b0001, '0, "blank");
    checkOutput("blank_st", 32'(st), 32'd1);
    applyStimulus(0, 1, 0, 4'b0001, '0, "blank_end");
    checkOutput("run_st", 32'(st), 32'd2);
    checkOutput("blank_noflt", 32'(flt), 32'd0);

    repeat_stim(2, 0, 1, 0, 4'b0100, '0, "pulse2");
    repeat_stim(2, 0, 1, 0, '0, '0, "gap");
    checkOutput("pulse_noflt", 32'(flt), 32'd0);
    repeat_stim(3, 0, 1, 0, 4'b0100, '0, "qual3");
    checkOutput("qual_src", 32'(flt_src), 32'b0100);
    checkOutput("qual_o", 32'(o), 32'd0);
    checkOutput("qual_st", 32'(st), 32'd3);
    repeat_stim(2, 0, 0, 0, 4'b1111, 4'b1010, "fault_hold");

    applyStimulus(0, 1, 1, '0, '0, "clr_en");
    repeat_stim(8, 0, 1, 0, '0, '0, "blank2");
    checkOutput("run2_st", 32'(st), 32'd2);

    repeat_stim(10, 0, 1, 0, 4'b0010, 4'b0010, "masked");
    checkOutput("masked_noflt", 32'(flt), 32'd0);
    repeat_stim(2, 0, 1, 0, 4'b0010, '0, "unmask");
    checkOutput("unmask_pending", 32'(flt), 32'd0);
    applyStimulus(0, 1, 0, 4'b0010, '0, "unmask3");
    checkOutput("unmask_src", 32'(flt_src), 32'b0010);

    applyStimulus(0, 1, 1, 4'b0001, '0, "clr_pri");
    checkOutput("clr_pri_st", 32'(st), 32'd1);
    checkOutput("clr_pri_flt", 32'(flt), 32'd0);
    repeat_stim(8, 0, 1, 0, 4'b0001, '0, "blank3");
    repeat_stim(3, 0, 1, 0, 4'b0001, '0, "q0");
    checkOutput("q0_src", 32'(flt_src), 32'b0001);
    applyStimulus(0, 0, 1, 4'b0001, '0, "clr_idle");
    checkOutput("clr_idle_st", 32'(st), 32'd0);

    repeat_stim(4, 0, 1, 0, '0, '0, "blank4");
    applyStimulus(1, 1, 1, 4'b1111, '0, "rst_blank");
    checkOutput("rst_blank_st", 32'(st), 32'd0);
    repeat_stim(9, 0, 1, 0, '0, '0, "to_run");
    repeat_stim(3, 0, 1, 0, 4'b1001, '0, "q_multi");
    checkOutput("q_multi_src", 32'(flt_src), 32'b1001);
    applyStimulus(1, 1, 1, 4'b1111, '0, "rst_fault");
    checkOutput("rst_fault_flt", 32'(flt), 32'd0);
    checkOutput("rst_fault_st", 32'(st), 32'd0);

    rnd_m = '0;
    for (int c = 0; c < 500; c++) begin
      for (int k = 0; k < N; k++) rnd_i[k] = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 7) == 0) rnd_m = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
      applyStimulus($urandom_range(0, 149) == 0, $urandom_range(0, 24) != 0,
                    $urandom_range(0, 5) == 0, rnd_i, rnd_m, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
